// File: rtl/b_bus_arbiter.sv
// B-bus source arbiter: grants one of three requesters for a len+1 beat burst, then one grounded GAP cycle.
// Optional feature: define B_BUS_ARB_RR_EN for round-robin arbitration (default build is fixed priority 0>1>2).
module b_bus_arbiter #(
   parameter int LEN_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         req,
   input  logic [3*LEN_W-1:0] req_len,
   output logic [2:0]         gnt,
   output logic [1:0]         b_sel,
   output logic               busy,
   output logic [2:0]         done
);

   localparam logic [1:0] SEL_GROUND = 2'b01;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt, win_len;
   logic [2:0]       gnt_nxt, win_gnt;
   logic [1:0]       b_sel_nxt, win_sel, winner;
`ifdef B_BUS_ARB_RR_EN
   logic [1:0]       last, last_nxt;
`endif

   // Later assignments take precedence, so each list is written lowest priority first.
   always_comb begin
      winner = 2'd0;
`ifdef B_BUS_ARB_RR_EN
      case (last)
         2'd0: begin
            if (req[0]) winner = 2'd0;
            if (req[2]) winner = 2'd2;
            if (req[1]) winner = 2'd1;
         end
         2'd1: begin
            if (req[1]) winner = 2'd1;
            if (req[0]) winner = 2'd0;
            if (req[2]) winner = 2'd2;
         end
         default: begin
            if (req[2]) winner = 2'd2;
            if (req[1]) winner = 2'd1;
            if (req[0]) winner = 2'd0;
         end
      endcase
`else
      if (req[2]) winner = 2'd2;
      if (req[1]) winner = 2'd1;
      if (req[0]) winner = 2'd0;
`endif
      case (winner)
         2'd1: begin
            win_len = req_len[LEN_W +: LEN_W];
            win_gnt = 3'b010;
            win_sel = 2'b11;
         end
         2'd2: begin
            win_len = req_len[2*LEN_W +: LEN_W];
            win_gnt = 3'b100;
            win_sel = 2'b01;
         end
         default: begin
            win_len = req_len[0 +: LEN_W];
            win_gnt = 3'b001;
            win_sel = 2'b00;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      b_sel_nxt = b_sel;
      done      = 3'b000;
`ifdef B_BUS_ARB_RR_EN
      last_nxt  = last;
`endif
      case (state)
         IDLE, GAP: begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
            b_sel_nxt = SEL_GROUND;
            if (|req) begin
               state_nxt = GRANT;
               cnt_nxt   = win_len;
               gnt_nxt   = win_gnt;
               b_sel_nxt = win_sel;
`ifdef B_BUS_ARB_RR_EN
               last_nxt  = winner;
`endif
            end
         end
         GRANT: begin
            // The last beat is the one where cnt has reached zero; the bus is grounded next cycle.
            if (cnt == '0) begin
               done      = gnt;
               state_nxt = GAP;
               gnt_nxt   = 3'b000;
               b_sel_nxt = SEL_GROUND;
            end else begin
               cnt_nxt = cnt - LEN_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
            b_sel_nxt = SEL_GROUND;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         gnt   <= 3'b000;
         b_sel <= SEL_GROUND;
`ifdef B_BUS_ARB_RR_EN
         last  <= 2'd2;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         b_sel <= b_sel_nxt;
`ifdef B_BUS_ARB_RR_EN
         last  <= last_nxt;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/b_bus_arbiter.md
# b_bus_arbiter

Arbiter and sequencer for the CPU B-bus source multiplexer. Three requesters (register file, external data port, zero-fill) compete for the B bus. The block grants one requester at a time for a fixed-length burst, drives the 2-bit B-bus select code for the 4:1 B-bus multiplexer, and inserts one grounded turnaround cycle between bursts. It sits between the control unit's request logic and the B-bus multiplexer.

## Interface
Parameters:
- LEN_W, 3, width of per-requester burst-length field; burst = len+1 beats (1..8).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  3  request lines; [0]=register source, [1]=external data, [2]=zero-fill.
- req_len  input  3*LEN_W  packed burst lengths; bits [LEN_W*i +: LEN_W] belong to requester i.
- gnt  output  3  one-hot grant, registered; all-zero when no owner.
- b_sel  output  2  registered B-bus select: 2'b00 register, 2'b11 ext_data, 2'b01 ground.
- busy  output  1  high while in GRANT or GAP.
- done  output  3  one-hot, one-cycle pulse on the owner's last beat.

## Operation
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is set, the arbitration winner is chosen, its req_len is latched into beat counter cnt, and the FSM goes to GRANT.
  - Otherwise the FSM stays in IDLE.
- GRANT:
  - gnt holds the owner's one-hot code.
  - b_sel holds the owner's code: 0→2'b00, 1→2'b11, 2→2'b01.
  - cnt decrements each cycle. When cnt==0, done[owner] pulses in that same cycle and the next state is GAP.
- GAP: exactly one cycle.
  - gnt=0, b_sel=2'b01.
  - Arbitration is performed as in IDLE. Next state is GRANT with the new winner, or IDLE if req==0.
- Request and length handling:
  - Requests are sampled only in IDLE or GAP.
  - A req drop or req_len change mid-burst is ignored; the burst always completes len+1 beats.
  - A requester may win consecutive bursts. The GAP cycle is still inserted.
- Winner selection: see Configuration. The last-owner pointer updates on every grant.
- Arithmetic: cnt is LEN_W bits and counts down only. There is no wrap, because the exit test is cnt==0.
- Invariants:
  - gnt has at most one bit set.
  - done is a subset of the gnt bits.
  - b_sel=2'b01 whenever gnt==0.

## Timing
- Reset values: gnt=3'b000, b_sel=2'b01, busy=0, done=3'b000, state=IDLE, cnt=0, last-owner pointer=2 (so requester 0 is searched first).
- Latency from req sampled high in IDLE to gnt high: 1 cycle. gnt and b_sel change on the same edge.
- Burst occupancy: len+1 GRANT cycles plus 1 GAP cycle.
- Back-to-back bursts: at most one idle bus cycle (the GAP) between grants.
- rst asserted mid-burst: at the next edge all outputs return to reset values, with no done pulse. The pointer is reset.
- Simultaneous events: done and the next arbitration never share a cycle. Arbitration happens in the GAP cycle after done.

## Configuration
- Macro B_BUS_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last owner + 1) mod 3.
- Undefined: fixed priority, 0 > 1 > 2, and the pointer is unused. A continuous req[0] starves requesters 1 and 2; this is accepted behaviour.

## Test plan
- Reset and idle:
  - Stimulus: rst high 2 cycles, then req=0 for 5 cycles.
  - Response: gnt=0, b_sel=2'b01, busy=0, done=0 throughout.
- Single burst:
  - Stimulus: req=3'b010 with len1=3 for one cycle in IDLE.
  - Response: gnt=3'b010 and b_sel=2'b11 for 4 cycles; done=3'b010 on the 4th; one GAP cycle (b_sel=2'b01, busy=1); then IDLE.
- Round-robin (macro defined):
  - Stimulus: req=3'b111 held, all len=0.
  - Response: grant order 0,1,2,0,1,2; b_sel sequence 00,01,11,01,01,01,00 (grant/GAP alternating).
- Fixed priority (macro undefined):
  - Stimulus: same as round-robin case.
  - Response: gnt=3'b001 on every grant; requesters 1 and 2 never granted.
- Mid-burst behaviour:
  - Stimulus: grant to requester 2 with len=7; drop req[2] and change req_len after 2 beats.
  - Response: still 8 beats with b_sel=2'b01 and done on beat 8.
- Reset mid-burst:
  - Stimulus: rst asserted during beat 3 of a len=5 burst.
  - Response: next cycle gnt=0, b_sel=2'b01, busy=0, no done pulse; a fresh req[1] afterwards is granted 1 cycle later.
